// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage definitions: shift opcodes and datapath width.
// The opcode encodings mirror funct[2:0] of the R-type shift instructions.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int AMT_W  = $clog2(DATA_W);

  typedef logic [2:0] shiftop_t;

  localparam shiftop_t SHIFTOP_SLL  = 3'b000;
  localparam shiftop_t SHIFTOP_SRL  = 3'b010;
  localparam shiftop_t SHIFTOP_SRA  = 3'b011;
  localparam shiftop_t SHIFTOP_SLLV = 3'b100;
  localparam shiftop_t SHIFTOP_SRLV = 3'b110;
  localparam shiftop_t SHIFTOP_SRAV = 3'b111;

  // Bit 2 selects rs as the amount source; bits [1:0] select the shift kind.
  function automatic logic shiftop_var_amt(input shiftop_t op);
    return op[2];
  endfunction

  function automatic logic shiftop_is_left(input shiftop_t op);
    return op[1:0] == 2'b00;
  endfunction

  function automatic logic shiftop_is_arith(input shiftop_t op);
    return op[1:0] == 2'b11;
  endfunction

  function automatic logic shiftop_illegal(input shiftop_t op);
    return op[1:0] == 2'b01;
  endfunction

endpackage

// File: rtl/barrel_shift_right.sv
// Combinational log-depth right barrel shifter with a caller-supplied fill bit.
// Stages shift by 16/8/4/2/1 in that order.
module barrel_shift_right
  import mips_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int AMT_W_P = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   data,
  input  logic [AMT_W_P-1:0] amt,
  input  logic               fill,
  output logic [WIDTH-1:0]   data_out
);

  logic [WIDTH-1:0] stage_data [0:AMT_W_P];

  assign stage_data[0] = data;

  generate
    for (genvar gi = 0; gi < AMT_W_P; gi++) begin : g_stage
      localparam int SH = 1 << (AMT_W_P - 1 - gi);
      assign stage_data[gi+1] = amt[AMT_W_P-1-gi]
                              ? {{SH{fill}}, stage_data[gi][WIDTH-1:SH]}
                              : stage_data[gi];
    end
  endgenerate

  assign data_out = stage_data[AMT_W_P];

endmodule

// File: rtl/mips_shifter.sv
// MIPS-I shift unit: decode, amount select, one shared right barrel and
// bit-reversal for left shifts, with a single output register stage.
module mips_shifter
  import mips_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [4:0]       shamt_in,
  input  logic [2:0]       shiftop,
  output logic [WIDTH-1:0] shift_out,
  output logic             out_valid,
  output logic             illegal_op
);

  localparam int AW = $clog2(WIDTH);

  logic [AW-1:0]    amt;
  logic             is_left;
  logic             is_arith;
  logic             is_illegal;
  logic             fill;
  logic [WIDTH-1:0] rt_rev;
  logic [WIDTH-1:0] shr_in;
  logic [WIDTH-1:0] shr_out;
  logic [WIDTH-1:0] shr_out_rev;
  logic [WIDTH-1:0] shift_out_next;
  logic [WIDTH-1:0] shift_out_reg;
  logic             out_valid_reg;
  logic             illegal_op_reg;

  // Only the low amount bits of rs matter; the rest are deliberately dropped.
  logic unused_rs_bits;
  assign unused_rs_bits = ^rs[WIDTH-1:AW];

  assign is_left    = shiftop_is_left(shiftop);
  assign is_arith   = shiftop_is_arith(shiftop);
  assign is_illegal = shiftop_illegal(shiftop);
  assign amt        = shiftop_var_amt(shiftop) ? rs[AW-1:0] : shamt_in[AW-1:0];
  assign fill       = is_arith & rt[WIDTH-1];

  // A left shift is a zero-fill right shift of the reversed word, reversed back.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
      assign rt_rev[gi]      = rt[WIDTH-1-gi];
      assign shr_out_rev[gi] = shr_out[WIDTH-1-gi];
    end
  endgenerate

  assign shr_in = is_left ? rt_rev : rt;

  barrel_shift_right #(
    .WIDTH   (WIDTH),
    .AMT_W_P (AW)
  ) u_barrel (
    .data     (shr_in),
    .amt      (amt),
    .fill     (fill),
    .data_out (shr_out)
  );

  always_comb begin
    shift_out_next = shr_out;
    if (is_illegal) begin
      shift_out_next = '0;
    end else if (is_left) begin
      shift_out_next = shr_out_rev;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_out_reg  <= '0;
      out_valid_reg  <= 1'b0;
      illegal_op_reg <= 1'b0;
    end else begin
      shift_out_reg  <= shift_out_next;
      out_valid_reg  <= in_valid;
      illegal_op_reg <= in_valid & is_illegal;
    end
  end

  assign shift_out  = shift_out_reg;
  assign out_valid  = out_valid_reg;
  assign illegal_op = illegal_op_reg;

endmodule

// File: tb/tb_mips_shifter.sv
// Directed and random checks of mips_shifter against hand values and a
// behavioural shift model.
module tb_mips_shifter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [4:0]  shamt_in;
  logic [2:0]  shiftop;
  logic [31:0] shift_out;
  logic        out_valid;
  logic        illegal_op;

  int n_checks;
  int n_pass;

  mips_shifter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .rs         (rs),
    .rt         (rt),
    .shamt_in   (shamt_in),
    .shiftop    (shiftop),
    .shift_out  (shift_out),
    .out_valid  (out_valid),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_shift(input logic [2:0] op, input logic [31:0] a_rs,
                                           input logic [31:0] a_rt, input logic [4:0] a_sh);
    logic [4:0] a;
    a = op[2] ? a_rs[4:0] : a_sh;
    case (op[1:0])
      2'b00:   return a_rt << a;
      2'b10:   return a_rt >> a;
      2'b11:   return 32'($signed(a_rt) >>> a);
      default: return 32'h0;
    endcase
  endfunction

  // Drive one op, wait one edge, and check all three outputs.
  task automatic apply(input string tag, input logic [2:0] op, input logic [31:0] a_rs,
                       input logic [31:0] a_rt, input logic [4:0] a_sh, input logic v,
                       input logic [31:0] exp_out, input logic exp_ill, input bit quiet);
    shiftop  = op;
    rs       = a_rs;
    rt       = a_rt;
    shamt_in = a_sh;
    in_valid = v;
    @(posedge clk);
    #1;
    if (!quiet)
      $display("%-10s op=%03b rs=%08h rt=%08h sh=%0d v=%0b -> out=%08h ov=%0b ill=%0b",
               tag, op, a_rs, a_rt, a_sh, v, shift_out, out_valid, illegal_op);
    check({tag, ".out"}, shift_out, exp_out);
    check({tag, ".ov"}, {31'b0, out_valid}, {31'b0, v});
    check({tag, ".ill"}, {31'b0, illegal_op}, {31'b0, exp_ill});
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] r_rs, r_rt;
    logic [4:0]  r_sh;
    logic        r_v;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    rs = 32'hFFFF_FFFF; rt = 32'h1234_5678; shamt_in = 5'd3; shiftop = 3'b000;

    // Reset held with live inputs and a running clock
    repeat (4) begin
      @(posedge clk);
      rt = $urandom; rs = $urandom; shamt_in = 5'($urandom); shiftop = 3'($urandom);
    end
    #1;
    $display("reset      held -> out=%08h ov=%0b ill=%0b", shift_out, out_valid, illegal_op);
    check("rst.out", shift_out, 32'h0);
    check("rst.ov", {31'b0, out_valid}, 32'h0);
    check("rst.ill", {31'b0, illegal_op}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Constant-amount shifts
    apply("sll",  3'b000, 32'hFF00F000, 32'hFF000002, 5'd6, 1'b1, 32'hC0000080, 1'b0, 1'b0);
    apply("srl",  3'b010, 32'hFF00F000, 32'hFF000002, 5'd6, 1'b1, 32'h03FC0000, 1'b0, 1'b0);
    apply("sra",  3'b011, 32'hFF00F000, 32'hFF000002, 5'd6, 1'b1, 32'hFFFC0000, 1'b0, 1'b0);

    // Variable shifts with rs[4:0] = 0: shamt_in must be ignored
    apply("sllv0", 3'b100, 32'hFF00F000, 32'hFF000002, 5'd6, 1'b1, 32'hFF000002, 1'b0, 1'b0);
    apply("srlv0", 3'b110, 32'hFF00F000, 32'hFF000002, 5'd6, 1'b1, 32'hFF000002, 1'b0, 1'b0);
    apply("srav0", 3'b111, 32'hFF00F000, 32'hFF000002, 5'd6, 1'b1, 32'hFF000002, 1'b0, 1'b0);

    // Maximum amount from rs
    apply("srlv31", 3'b110, 32'hFFFFFFFF, 32'h80000000, 5'd0, 1'b1, 32'h00000001, 1'b0, 1'b0);
    apply("srav31", 3'b111, 32'hFFFFFFFF, 32'h80000000, 5'd0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    apply("sllv31", 3'b100, 32'hFFFFFFFF, 32'h80000000, 5'd0, 1'b1, 32'h00000000, 1'b0, 1'b0);
    apply("sllv31b", 3'b100, 32'hFFFFFFFF, 32'h00000001, 5'd0, 1'b1, 32'h80000000, 1'b0, 1'b0);
    apply("sra31", 3'b011, 32'h0, 32'h40000000, 5'd31, 1'b1, 32'h00000000, 1'b0, 1'b0);

    // Illegal encodings, with and without valid
    apply("ill001", 3'b001, 32'h00000003, 32'hDEADBEEF, 5'd4, 1'b1, 32'h0, 1'b1, 1'b0);
    apply("ill101", 3'b101, 32'h00000003, 32'hDEADBEEF, 5'd4, 1'b1, 32'h0, 1'b1, 1'b0);
    apply("ill001nv", 3'b001, 32'h00000003, 32'hDEADBEEF, 5'd4, 1'b0, 32'h0, 1'b0, 1'b0);
    apply("ill101nv", 3'b101, 32'h00000003, 32'hDEADBEEF, 5'd4, 1'b0, 32'h0, 1'b0, 1'b0);

    // Back-to-back stream: each result appears exactly one edge later
    apply("strm_sll",  3'b000, 32'h0000001F, 32'h0000F00D, 5'd8, 1'b1, 32'h00F00D00, 1'b0, 1'b0);
    apply("strm_sra",  3'b011, 32'h0000001F, 32'h8000F00D, 5'd4, 1'b1, 32'hF8000F00, 1'b0, 1'b0);
    apply("strm_srlv", 3'b110, 32'hABCDEF04, 32'h8000F00D, 5'd9, 1'b1, 32'h08000F00, 1'b0, 1'b0);
    apply("strm_srav", 3'b111, 32'h12345610, 32'h8000F00D, 5'd1, 1'b1, 32'hFFFF8000, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle clears outputs before any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    $display("reset      async -> out=%08h ov=%0b ill=%0b", shift_out, out_valid, illegal_op);
    check("arst.out", shift_out, 32'h0);
    check("arst.ov", {31'b0, out_valid}, 32'h0);
    // The in-flight transaction is discarded while reset stays low
    @(posedge clk);
    #1;
    check("arst.hold", shift_out, 32'h0);
    check("arst.hov", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    apply("post_rst", 3'b000, 32'h0, 32'h00000001, 5'd31, 1'b1, 32'h80000000, 1'b0, 1'b0);

    // Random sweep against the behavioural model
    for (int i = 0; i < 10000; i++) begin
      op   = 3'($urandom);
      r_rs = $urandom;
      r_rt = $urandom;
      r_sh = 5'($urandom);
      r_v  = 1'($urandom);
      apply("rand", op, r_rs, r_rt, r_sh, r_v, ref_shift(op, r_rs, r_rt, r_sh),
            r_v & (op[1:0] == 2'b01), 1'b1);
    end
    $display("random sweep of 10000 vectors complete");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
